clock_nth_weekday_date: RTL

- Inverse of the date→weekday path.
- Given a BCD year, a BCD month, a target weekday and an occurrence ("2nd Sunday", "last Sunday"), computes the BCD day-of-month on which that weekday falls.
- Feeds DST-switch and recurring-alarm scheduling in the clock/calendar subsystem.
- Uses Conway's doomsday method internally, with a start/busy/done handshake and iterative division.

---
 rtl/clock_nth_weekday_date_pkg.sv | 53 +++++
 rtl/clock_nth_weekday_date_mod7.sv | 7 +
 rtl/clock_nth_weekday_date.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/clock_nth_weekday_date_pkg.sv
// Shared calendar tables and codes for the weekday/date blocks.
package clock_nth_weekday_date_pkg;

  typedef enum logic [2:0] {
    WD_SUN = 3'd0, WD_MON = 3'd1, WD_TUE = 3'd2, WD_WED = 3'd3,
    WD_THU = 3'd4, WD_FRI = 3'd5, WD_SAT = 3'd6
  } weekday_t;

  localparam logic [2:0] OCC_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIV12, S_DOOM, S_FIRST, S_NTH, S_BCD, S_DONE
  } state_t;

  // Doomsday anchor date of each month (day that shares the year's doomsday weekday).
  function automatic logic [4:0] anchor_date(input logic [3:0] month, input logic leap);
    case (month)
      4'd1:    return 5'd3 + 5'(leap);
      4'd2:    return 5'd28 + 5'(leap);
      4'd3:    return 5'd14;
      4'd4:    return 5'd4;
      4'd5:    return 5'd9;
      4'd6:    return 5'd6;
      4'd7:    return 5'd11;
      4'd8:    return 5'd8;
      4'd9:    return 5'd5;
      4'd10:   return 5'd10;
      4'd11:   return 5'd7;
      4'd12:   return 5'd12;
      default: return 5'd0;
    endcase
  endfunction

  // Days in month.
  function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
    case (month)
      4'd2:                     return 5'd28 + 5'(leap);
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

  // Century anchor weekday indexed by the century number mod 4.
  function automatic logic [2:0] century_code(input logic [1:0] cc_lo);
    case (cc_lo)
      2'd0:    return 3'd2;
      2'd1:    return 3'd0;
      2'd2:    return 3'd5;
      default: return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/clock_nth_weekday_date_mod7.sv
// Combinational remainder modulo 7 for small sums (0..63).
module clock_mod7 (
  input  logic [5:0] a,
  output logic [2:0] rem
);
  assign rem = 3'(a % 6'd7);
endmodule

// File: rtl/clock_nth_weekday_date.sv
// Nth / last weekday of a month -> BCD day-of-month, via Conway's doomsday rule.
module clock_nth_weekday_date
  import clock_nth_weekday_date_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       Is_Leap_Year,
  input  logic [3:0] clock_year,
  input  logic [3:0] clock_decade,
  input  logic [3:0] clock_century,
  input  logic [3:0] clock_millenia,
  input  logic [3:0] clock_1month,
  input  logic [3:0] clock_10month,
  input  logic [2:0] target_weekday,
  input  logic [2:0] occurrence,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] clock_day,
  output logic [3:0] clock_10day
);

  state_t state, next_state;

  // captured request
  logic [3:0] c_yr, c_dec, c_cen, c_mil, c_m1, c_m10;
  logic       c_leap;
  logic [2:0] c_wd, c_occ;

  // working registers
  logic [6:0] yy;
  logic [3:0] q;
  logic [2:0] cent;
  logic [3:0] month;
  logic [2:0] doom;
  logic [3:0] first;
  logic [5:0] n;
  logic [1:0] tens;

  // combinational helpers
  logic       digit_bad, chk_err, nth_err, last_occ, fail, enter_done;
  logic [6:0] mon_full;
  logic [1:0] cc_lo;
  logic [5:0] doom_sum, first_sum, mod_a_in, mod_b_in;
  logic [2:0] mod_a_out, mod_b_out;
  logic [5:0] ml, n_nth, n_last28, n_last21, n_sel;

  // Input validation and CHECK-stage derived values.
  always_comb begin
    digit_bad = (c_yr > 4'd9) | (c_dec > 4'd9) | (c_cen > 4'd9) | (c_mil > 4'd9) |
                (c_m1 > 4'd9) | (c_m10 > 4'd9);
    mon_full  = 7'(c_m10) * 7'd10 + 7'(c_m1);
    chk_err   = digit_bad | (mon_full == 7'd0) | (mon_full > 7'd12) |
                (c_wd > WD_SAT) | (c_occ == 3'd0) | (c_occ == 3'd6);
    // (10*mil + cen) mod 4 == (2*mil + cen) mod 4; only the low two bits matter
    cc_lo     = {c_mil[0], 1'b0} + c_cen[1:0];
  end

  // Doomsday sum (DOOM) and weekday of the 1st (FIRST) share one mod-7 unit.
  always_comb begin
    doom_sum  = 6'(cent) + 6'(q) + 6'(yy) + 6'(yy >> 2);
    first_sum = 6'(doom) + 6'd36 - 6'(anchor_date(month, c_leap));
    mod_a_in  = (state == S_DOOM) ? doom_sum : first_sum;
    mod_b_in  = 6'(c_wd) + 6'd7 - 6'(mod_a_out);
  end

  clock_mod7 u_mod7_a (.a(mod_a_in), .rem(mod_a_out));
  clock_mod7 u_mod7_b (.a(mod_b_in), .rem(mod_b_out));

  // Occurrence -> day number, with last-occurrence fallback and overflow check.
  always_comb begin
    ml       = 6'(month_len(month, c_leap));
    n_nth    = 6'(first) + 6'(c_occ - 3'd1) * 6'd7;
    n_last28 = 6'(first) + 6'd28;
    n_last21 = 6'(first) + 6'd21;
    last_occ = (c_occ == OCC_LAST);
    n_sel    = last_occ ? ((n_last28 <= ml) ? n_last28 : n_last21) : n_nth;
    nth_err  = !last_occ && (n_nth > ml);
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; both iterative loops spin in place until their exit test.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CHECK;
      S_CHECK: next_state = chk_err ? S_DONE : S_DIV12;
      S_DIV12: if (yy < 7'd12) next_state = S_DOOM;
      S_DOOM:  next_state = S_FIRST;
      S_FIRST: next_state = S_NTH;
      S_NTH:   next_state = nth_err ? S_DONE : S_BCD;
      S_BCD:   if (n < 6'd10) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    fail       = ((state == S_CHECK) && chk_err) || ((state == S_NTH) && nth_err);
    enter_done = (next_state == S_DONE) && (state != S_DONE);
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Capture, division by 12, doomsday, first-day, nth and BCD datapath.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      {c_yr, c_dec, c_cen, c_mil, c_m1, c_m10} <= '0;
      c_leap <= 1'b0;
      c_wd   <= '0;
      c_occ  <= '0;
      yy     <= '0;
      q      <= '0;
      cent   <= '0;
      month  <= '0;
      doom   <= '0;
      first  <= '0;
      n      <= '0;
      tens   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          c_yr   <= clock_year;
          c_dec  <= clock_decade;
          c_cen  <= clock_century;
          c_mil  <= clock_millenia;
          c_m1   <= clock_1month;
          c_m10  <= clock_10month;
          c_leap <= Is_Leap_Year;
          c_wd   <= target_weekday;
          c_occ  <= occurrence;
        end
        S_CHECK: begin
          yy    <= 7'(c_dec) * 7'd10 + 7'(c_yr);
          q     <= '0;
          cent  <= century_code(cc_lo);
          month <= mon_full[3:0];
          tens  <= '0;
        end
        S_DIV12: if (yy >= 7'd12) begin
          yy <= yy - 7'd12;
          q  <= q + 4'd1;
        end
        S_DOOM:  doom  <= mod_a_out;
        S_FIRST: first <= 4'd1 + 4'(mod_b_out);
        S_NTH:   n     <= n_sel;
        S_BCD: if (n >= 6'd10) begin
          n    <= n - 6'd10;
          tens <= tens + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers load on entry to DONE and hold until the next result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      error       <= 1'b0;
      clock_day   <= '0;
      clock_10day <= '0;
    end else if (enter_done) begin
      error       <= fail;
      clock_day   <= fail ? 4'd0 : n[3:0];
      clock_10day <= fail ? 4'd0 : {2'b00, tens};
    end
  end

endmodule
